dmem_access_ctrl: RTL and testbench

Sequencing controller and arbiter for the single-port data memory used by the MEM stage. Shares the memory between the pipeline MEM stage and a loader/debug port, and inserts a configurable number of wait states per access. Stalls the pipeline with a combinational stall output until the pipeline's access completes. Sits between the EX/MEM latch outputs and the data memory, upstream of the MEM/WB latch.

---
 rtl/dmem_access_ctrl.sv | 114 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Arbiter and wait-state sequencer for the MEM-stage data memory. The pipeline and a
// loader/debug port share one single-port memory; each access occupies WAIT_STATES+1 cycles.
module dmem_access_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WAIT_STATES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_memread,
    input  logic              pipe_memwrite,
    input  logic [ADDR_W-1:0] pipe_address,
    input  logic [DATA_W-1:0] pipe_write_data,
    output logic              pipe_stall,
    output logic [DATA_W-1:0] pipe_read_data,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    localparam int            SW         = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [3:0]    WAIT_LOAD  = 4'(WAIT_STATES);
    localparam bit            AGING      = (STARVE_LIMIT != 0);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t            r_state;
    logic [3:0]        r_wait;
    logic [SW-1:0]     r_starve;
    logic              r_owner_ld;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_pipe_rdata;
    logic [DATA_W-1:0] r_ld_rdata;

    logic w_pipe_act;
    logic w_starved;
    logic w_ld_win;

    assign w_pipe_act = pipe_memread | pipe_memwrite;
    assign w_starved  = AGING & (r_starve == STARVE_MAX);
    // Loader takes the memory when the pipeline is quiet or has beaten it too often in a row.
    assign w_ld_win   = ld_req & (~w_pipe_act | w_starved);

    assign pipe_stall     = w_pipe_act & ~((r_state == S_RESP) & ~r_owner_ld);
    assign ld_gnt         = reset & (r_state == S_IDLE) & w_ld_win;
    assign ld_done        = (r_state == S_RESP) & r_owner_ld;
    assign mem_memread    = (r_state == S_BUSY) & ~r_we;
    assign mem_memwrite   = (r_state == S_BUSY) & r_we;
    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;
    assign busy           = (r_state != S_IDLE);
    assign pipe_read_data = r_pipe_rdata;
    assign ld_rdata       = r_ld_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_wait       <= '0;
            r_starve     <= '0;
            r_owner_ld   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_pipe_rdata <= '0;
            r_ld_rdata   <= '0;
        end else begin
            if (!ld_req) r_starve <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_pipe_act | ld_req) begin
                        r_owner_ld <= w_ld_win;
                        r_addr     <= w_ld_win ? ld_addr  : pipe_address;
                        r_wdata    <= w_ld_win ? ld_wdata : pipe_write_data;
                        r_we       <= w_ld_win ? ld_we    : pipe_memwrite;
                        r_wait     <= WAIT_LOAD;
                        r_state    <= S_BUSY;
                        if (w_ld_win)
                            r_starve <= '0;
                        else if (ld_req && r_starve != STARVE_MAX)
                            r_starve <= r_starve + SW'(1);
                    end
                end
                S_BUSY: begin
                    if (r_wait == 4'd0) begin
                        if (!r_we) begin
                            if (r_owner_ld) r_ld_rdata   <= mem_read_data;
                            else            r_pipe_rdata <= mem_read_data;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus random traffic checked each cycle
// against a timestamp-based transaction model of the arbiter.
module tb_dmem_access_ctrl;
    localparam int WS = 2;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        pipe_memread = 0, pipe_memwrite = 0;
    logic [31:0] pipe_address = 0, pipe_write_data = 0;
    logic        pipe_stall;
    logic [31:0] pipe_read_data;
    logic        ld_req = 0, ld_we = 0;
    logic [31:0] ld_addr = 0, ld_wdata = 0;
    logic        ld_gnt, ld_done;
    logic [31:0] ld_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_memread, mem_memwrite, busy;

    // Second instance with aging disabled
    logic        z_pipe_memread = 0, z_pipe_memwrite = 0;
    logic [31:0] z_pipe_address = 0, z_pipe_write_data = 0;
    logic        z_pipe_stall;
    logic [31:0] z_pipe_read_data;
    logic        z_ld_req = 0, z_ld_we = 0;
    logic [31:0] z_ld_addr = 0, z_ld_wdata = 0;
    logic        z_ld_gnt, z_ld_done;
    logic [31:0] z_ld_rdata;
    logic [31:0] z_mem_address, z_mem_write_data, z_mem_read_data;
    logic        z_mem_memread, z_mem_memwrite, z_busy;

    int checks = 0, failures = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign mem_read_data   = memf(mem_address);
    assign z_mem_read_data = memf(z_mem_address);

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(rst_n),
        .pipe_memread(pipe_memread), .pipe_memwrite(pipe_memwrite),
        .pipe_address(pipe_address), .pipe_write_data(pipe_write_data),
        .pipe_stall(pipe_stall), .pipe_read_data(pipe_read_data),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_done(ld_done), .ld_rdata(ld_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS), .STARVE_LIMIT(0)) dut0 (
        .clk(clk), .reset(rst_n),
        .pipe_memread(z_pipe_memread), .pipe_memwrite(z_pipe_memwrite),
        .pipe_address(z_pipe_address), .pipe_write_data(z_pipe_write_data),
        .pipe_stall(z_pipe_stall), .pipe_read_data(z_pipe_read_data),
        .ld_req(z_ld_req), .ld_we(z_ld_we), .ld_addr(z_ld_addr), .ld_wdata(z_ld_wdata),
        .ld_gnt(z_ld_gnt), .ld_done(z_ld_done), .ld_rdata(z_ld_rdata),
        .mem_address(z_mem_address), .mem_write_data(z_mem_write_data),
        .mem_memread(z_mem_memread), .mem_memwrite(z_mem_memwrite),
        .mem_read_data(z_mem_read_data), .busy(z_busy)
    );

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: an access granted at cycle g is busy for cycles g+1..g+WS+1
    // and responds in cycle g+WS+2.
    int          m_c = 0, m_resp = 0, m_starve = 0;
    logic        m_active = 0, m_owner = 0, m_we = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_prd = 0, m_lrd = 0;
    logic        tb_preq, exp_lw, m_in_busy, m_in_resp;

    assign tb_preq   = pipe_memread | pipe_memwrite;
    assign exp_lw    = ld_req && (!tb_preq || (SL != 0 && m_starve == SL));
    assign m_in_busy = m_active && (m_c < m_resp);
    assign m_in_resp = m_active && (m_c == m_resp);

    always @(posedge clk) m_c <= m_c + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 0; m_owner <= 0; m_we <= 0; m_starve <= 0;
            m_addr <= 0; m_wdata <= 0; m_prd <= 0; m_lrd <= 0;
        end else begin
            if (!m_active) begin
                if (tb_preq || ld_req) begin
                    m_active <= 1;
                    m_owner  <= exp_lw;
                    m_addr   <= exp_lw ? ld_addr  : pipe_address;
                    m_wdata  <= exp_lw ? ld_wdata : pipe_write_data;
                    m_we     <= exp_lw ? ld_we    : pipe_memwrite;
                    m_resp   <= m_c + WS + 2;
                end
            end else begin
                if (m_c == m_resp - 1 && !m_we) begin
                    if (m_owner) m_lrd <= memf(m_addr);
                    else         m_prd <= memf(m_addr);
                end
                if (m_c == m_resp) m_active <= 0;
            end
            if (!ld_req)
                m_starve <= 0;
            else if (!m_active)
                m_starve <= exp_lw ? 0 : ((m_starve < SL) ? m_starve + 1 : m_starve);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk1 ("busy",           busy,           m_active);
            chk1 ("mem_memread",    mem_memread,    m_in_busy && !m_we);
            chk1 ("mem_memwrite",   mem_memwrite,   m_in_busy && m_we);
            chk32("mem_address",    mem_address,    m_addr);
            chk32("mem_write_data", mem_write_data, m_wdata);
            chk1 ("ld_done",        ld_done,        m_in_resp && m_owner);
            chk1 ("ld_gnt",         ld_gnt,         !m_active && exp_lw);
            chk1 ("pipe_stall",     pipe_stall,     tb_preq && !(m_in_resp && !m_owner));
            chk32("pipe_read_data", pipe_read_data, m_prd);
            chk32("ld_rdata",       ld_rdata,       m_lrd);
        end
    end

    // Aging: with both sides always requesting, the pipeline wins exactly SL times in a row
    logic cont_mon = 0;
    int   pcnt = 0;
    always @(negedge clk) begin
        if (!cont_mon || !rst_n) pcnt <= 0;
        else if (!busy && tb_preq) begin
            if (ld_gnt) begin
                chk32("starve_pipe_wins", 32'(pcnt), 32'(SL));
                pcnt <= 0;
            end else begin
                pcnt <= pcnt + 1;
            end
        end
    end

    task automatic new_pipe(input int mode);
        int r;
        r = (mode == 1) ? $urandom_range(4, 9) : $urandom_range(0, 9);
        if (mode == 2 || r < 4) begin pipe_memread = 0; pipe_memwrite = 0; end
        else if (r < 7)         begin pipe_memread = 1; pipe_memwrite = 0; end
        else if (r < 9)         begin pipe_memread = 0; pipe_memwrite = 1; end
        else                    begin pipe_memread = 1; pipe_memwrite = 1; end
        pipe_address    = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        pipe_write_data = $urandom;
    endtask

    task automatic new_ld(input int mode);
        ld_req   = (mode == 1) ? 1'b1 : ((mode == 0) && ($urandom_range(0, 9) < 3));
        ld_we    = 1'($urandom_range(0, 1));
        ld_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        ld_wdata = $urandom;
    endtask

    // mode 0: random, 1: both sides continuously requesting, 2: drain to idle
    task automatic run(input int mode, input int ncyc);
        logic pd, lg;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            pd = tb_preq & ~pipe_stall;
            lg = ld_gnt;
            @(posedge clk); #1;
            if (!tb_preq || pd) new_pipe(mode);
            if (ld_req && !lg) begin
                if (mode == 0 && $urandom_range(0, 19) == 0) ld_req = 0;
            end else begin
                new_ld(mode);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1 ("rst_busy",      busy, 0);
        chk1 ("rst_memread",   mem_memread, 0);
        chk1 ("rst_memwrite",  mem_memwrite, 0);
        chk1 ("rst_ld_gnt",    ld_gnt, 0);
        chk1 ("rst_ld_done",   ld_done, 0);
        chk32("rst_prd",       pipe_read_data, 0);
        chk32("rst_lrd",       ld_rdata, 0);
        chk32("rst_addr",      mem_address, 0);
        pipe_memread = 1; #1;
        chk1 ("rst_stall_eq",  pipe_stall, 1);
        pipe_memread = 0;
        @(posedge clk); #3 rst_n = 1;

        // Pipeline read of 0x10
        @(posedge clk); #1 pipe_memread = 1; pipe_address = 32'h10;
        for (int k = 0; k <= WS + 2; k++) begin
            @(negedge clk);
            chk1("t1_stall", pipe_stall, k < WS + 2);
            chk1("t1_memread", mem_memread, k >= 1 && k <= WS + 1);
            if (k == WS + 2) chk32("t1_prd", pipe_read_data, 32'hDEADBEEF);
        end
        @(posedge clk); #1 pipe_memread = 0;

        // Pipeline write with memread also set
        @(posedge clk); #1
        pipe_memread = 1; pipe_memwrite = 1; pipe_address = 32'h20; pipe_write_data = 32'h12345678;
        for (int k = 0; k <= WS + 2; k++) begin
            @(negedge clk);
            chk1("t2_memwrite", mem_memwrite, k >= 1 && k <= WS + 1);
            chk1("t2_memread", mem_memread, 0);
            if (k == 1) begin
                chk32("t2_addr", mem_address, 32'h20);
                chk32("t2_wdata", mem_write_data, 32'h12345678);
            end
            if (k == WS + 2) chk32("t2_prd_kept", pipe_read_data, 32'hDEADBEEF);
        end
        @(posedge clk); #1 pipe_memread = 0; pipe_memwrite = 0;

        // Loader read of 0x40
        @(posedge clk); #1 ld_req = 1; ld_we = 0; ld_addr = 32'h40;
        for (int k = 0; k <= WS + 2; k++) begin
            @(negedge clk);
            chk1("t3_gnt", ld_gnt, k == 0);
            chk1("t3_done", ld_done, k == WS + 2);
            chk1("t3_stall", pipe_stall, 0);
            if (k == WS + 2) chk32("t3_rdata", ld_rdata, memf(32'h40));
            if (k == 0) begin @(posedge clk); #1 ld_req = 0; end
        end

        // Reset in the second BUSY cycle
        @(posedge clk); #1 pipe_memread = 1; pipe_address = 32'h30;
        @(posedge clk);
        @(posedge clk); #2;
        chk1("t6_pre_busy", busy, 1);
        ld_req = 1; rst_n = 0; #1;
        chk1 ("t6_memread", mem_memread, 0);
        chk1 ("t6_memwrite", mem_memwrite, 0);
        chk1 ("t6_busy", busy, 0);
        chk1 ("t6_gnt", ld_gnt, 0);
        chk1 ("t6_done", ld_done, 0);
        chk32("t6_prd", pipe_read_data, 0);
        chk32("t6_lrd", ld_rdata, 0);
        chk1 ("t6_stall", pipe_stall, 1);
        ld_req = 0; pipe_memread = 0;
        @(posedge clk); @(posedge clk); #3 rst_n = 1;
        @(posedge clk); #1 pipe_memread = 1; pipe_address = 32'h10;
        for (int k = 0; k <= WS + 2; k++) begin
            @(negedge clk);
            chk1("t6_re_stall", pipe_stall, k < WS + 2);
            if (k == WS + 2) chk32("t6_re_prd", pipe_read_data, 32'hDEADBEEF);
        end
        @(posedge clk); #1 pipe_memread = 0;

        // Random traffic, then continuous contention for aging
        run(0, 2500);
        run(2, 30);
        cont_mon = 1;
        run(1, 300);
        cont_mon = 0;
        run(2, 30);

        // Strict priority instance: loader waits until the pipeline goes quiet
        @(posedge clk); #1
        z_pipe_memread = 1; z_pipe_address = 32'h10; z_ld_req = 1; z_ld_addr = 32'h44;
        for (int n = 0; n < 40; n++) begin
            logic zpd;
            @(negedge clk);
            chk1("sl0_no_gnt", z_ld_gnt, 0);
            zpd = z_pipe_memread & ~z_pipe_stall;
            @(posedge clk); #1;
            if (zpd) z_pipe_address = z_pipe_address ^ 32'h4;
        end
        begin
            logic got;
            got = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (z_pipe_memread && !z_pipe_stall) begin got = 1; break; end
            end
            chk1("sl0_pipe_done", got, 1);
            @(posedge clk); #1 z_pipe_memread = 0;
            @(negedge clk);
            chk1("sl0_gnt_first_idle", z_ld_gnt, 1);
            @(posedge clk); #1 z_ld_req = 0;
            got = 0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (z_ld_done) begin got = 1; break; end
            end
            chk1("sl0_ld_done", got, 1);
            chk32("sl0_ld_rdata", z_ld_rdata, memf(32'h44));
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
